exhaustive_stim_ctrl: RTL

Hardware sequencer that drives every input combination of a small combinational DUT, such as the 5-input problem circuits, and checks each response against a golden truth table. It replaces the procedural for-loop stimulus with a synthesizable, self-checking controller. It sits between a start/status interface and the DUT's input/output pins. It reports a pass/fail flag, a mismatch count, the first failing vector and the full captured response map.

---
 rtl/exhaustive_stim_ctrl_if.sv | 15 +
 rtl/exhaustive_stim_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/exhaustive_stim_ctrl_if.sv
// exhaustive_stim_ctrl_if: start/status and DUT-pin bundle between host, controller and circuit under test
interface exhaustive_stim_ctrl_if #(parameter int N_IN = 5);
  logic start, abort, dut_out, busy, done, pass, first_fail_valid;
  logic [N_IN-1:0] dut_ins, first_fail_idx;
  logic [N_IN:0] err_count;
  logic [2**N_IN-1:0] captured;
  modport master (
    output start, abort, dut_out,
    input dut_ins, busy, done, pass, err_count, first_fail_idx, first_fail_valid, captured
  );
  modport slave (
    input start, abort, dut_out,
    output dut_ins, busy, done, pass, err_count, first_fail_idx, first_fail_valid, captured
  );
endinterface

// File: rtl/exhaustive_stim_ctrl.sv
// exhaustive_stim_ctrl: walks every input vector of a small combinational circuit and checks it against a golden truth table
module exhaustive_stim_ctrl #(
  parameter int N_IN = 5,
  parameter int SETTLE = 2,
  parameter logic [2**N_IN-1:0] EXPECTED = 32'h9669_6996
) (
  input logic clk,
  input logic rst_n,
  exhaustive_stim_ctrl_if.slave bus
);
  localparam int N = 2**N_IN;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d, dut_ins_q, dut_ins_d, ffi_q, ffi_d;
  logic [3:0] hold_q, hold_d;
  logic [N_IN:0] err_q, err_d;
  logic [N-1:0] cap_q, cap_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, ffv_q, ffv_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    hold_d = hold_q;
    err_d = err_q;
    cap_d = cap_q;
    ffi_d = ffi_q;
    ffv_d = ffv_q;
    pass_d = pass_q;
    unique case (state_q)
      IDLE: if (bus.start && !bus.abort) begin
        state_d = APPLY;
        idx_d = '0;
        hold_d = '0;
        err_d = '0;
        cap_d = '0;
        ffi_d = '0;
        ffv_d = 1'b0;
        pass_d = 1'b0;
      end
      APPLY: begin
        hold_d = hold_q + 4'd1;
        state_d = bus.abort ? IDLE : hold_q == 4'(SETTLE - 1) ? SAMPLE : APPLY;
        pass_d = bus.abort ? 1'b0 : pass_q;
      end
      SAMPLE: if (bus.abort) begin
        state_d = IDLE;
        pass_d = 1'b0;
      end else begin
        cap_d[idx_q] = bus.dut_out;
        if (bus.dut_out != EXPECTED[idx_q]) begin
          err_d = err_q + (N_IN+1)'(1);
          ffi_d = ffv_q ? ffi_q : idx_q;
          ffv_d = 1'b1;
        end
        // terminate on the last vector rather than letting idx wrap
        state_d = idx_q == '1 ? DONE : APPLY;
        idx_d = idx_q == '1 ? idx_q : idx_q + N_IN'(1);
        hold_d = '0;
        pass_d = idx_q == '1 ? err_d == '0 : pass_q;
      end
      DONE: state_d = IDLE;
    endcase
    busy_d = state_d == APPLY || state_d == SAMPLE;
    done_d = state_d == DONE;
    dut_ins_d = busy_d ? idx_d : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      hold_q <= '0;
      err_q <= '0;
      cap_q <= '0;
      ffi_q <= '0;
      ffv_q <= 1'b0;
      pass_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dut_ins_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      hold_q <= hold_d;
      err_q <= err_d;
      cap_q <= cap_d;
      ffi_q <= ffi_d;
      ffv_q <= ffv_d;
      pass_q <= pass_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dut_ins_q <= dut_ins_d;
    end
  end
  assign bus.dut_ins = dut_ins_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.err_count = err_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.captured = cap_q;
endmodule
